memory_arbiter: RTL

Shares the single `memory` access unit between the instruction-fetch path and the load/store path of the core. Each access runs a fixed three-state sequence that holds the memory unit's inputs stable while its `enable_n` is low. The block then returns the registered read data and the fault number to whichever requester was granted. It sits between the fetch/execute control logic and the `memory` instance, and it is the only driver of that instance's inputs.

---
 rtl/memory_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single memory access unit between the fetch path
// and the load/store path. Each access is IDLE -> ACCESS -> DONE, with the
// memory inputs held in registers so they stay stable while enable_n is low.
//
// Optional feature: define MEMORY_ARBITER_ROUND_ROBIN_EN to resolve
// simultaneous requests by granting whichever requester was not granted last.
// Without it, data always wins over fetch.
module memory_arbiter (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_done,
    output logic [31:0] fetch_data,
    output logic [2:0]  fetch_fault,

    input  logic        data_req,
    input  logic        data_is_write,
    input  logic        data_is_unsigned,
    input  logic [1:0]  data_op_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_done,
    output logic [31:0] data_rdata,
    output logic [2:0]  data_fault,

    output logic        mem_enable_n,
    output logic        mem_is_write,
    output logic        mem_is_unsigned,
    output logic [1:0]  mem_op_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    input  logic [2:0]  mem_fault_num,

    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    localparam logic OwnerFetch = 1'b0;
    localparam logic OwnerData  = 1'b1;

    // Fetches are always full-word reads.
    localparam logic [1:0] SizeWord = 2'b10;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        enable_n_q, enable_n_d;
    logic        is_write_q, is_write_d;
    logic        is_unsigned_q, is_unsigned_d;
    logic [1:0]  op_size_q, op_size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        grant_data;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic        last_grant_q, last_grant_d;

    // On contention, favour the requester that lost last time.
    assign grant_data = data_req && (!fetch_req || (last_grant_q == OwnerFetch));
`else
    assign grant_data = data_req;
`endif

    // Next-state logic: capture the winner's request in IDLE, then sequence.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        enable_n_d    = 1'b1;
        is_write_d    = is_write_q;
        is_unsigned_d = is_unsigned_q;
        op_size_d     = op_size_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        last_grant_d  = last_grant_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (fetch_req || data_req) begin
                    state_d    = StAccess;
                    enable_n_d = 1'b0;
                    if (grant_data) begin
                        owner_d       = OwnerData;
                        is_write_d    = data_is_write;
                        is_unsigned_d = data_is_unsigned;
                        op_size_d     = data_op_size;
                        addr_d        = data_addr;
                        wdata_d       = data_wdata;
                    end else begin
                        owner_d       = OwnerFetch;
                        is_write_d    = 1'b0;
                        is_unsigned_d = 1'b0;
                        op_size_d     = SizeWord;
                        addr_d        = fetch_addr;
                        wdata_d       = 32'h0;
                    end
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
                    last_grant_d = owner_d;
`endif
                end
            end
            StAccess: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State and request registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            owner_q       <= OwnerFetch;
            enable_n_q    <= 1'b1;
            is_write_q    <= 1'b0;
            is_unsigned_q <= 1'b0;
            op_size_q     <= 2'b00;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last_grant_q  <= OwnerFetch;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            enable_n_q    <= enable_n_d;
            is_write_q    <= is_write_d;
            is_unsigned_q <= is_unsigned_d;
            op_size_q     <= op_size_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    // Memory inputs come straight from flops so they never glitch.
    always_comb begin
        mem_enable_n    = enable_n_q;
        mem_is_write    = is_write_q;
        mem_is_unsigned = is_unsigned_q;
        mem_op_size     = op_size_q;
        mem_addr        = addr_q;
        mem_in          = wdata_q;
    end

    // Completion: route the memory result to the owner only, zero elsewhere.
    always_comb begin
        fetch_done  = (state_q == StDone) && (owner_q == OwnerFetch);
        data_done   = (state_q == StDone) && (owner_q == OwnerData);
        fetch_data  = fetch_done ? mem_out : 32'h0;
        fetch_fault = fetch_done ? mem_fault_num : 3'b000;
        data_rdata  = data_done ? mem_out : 32'h0;
        data_fault  = data_done ? mem_fault_num : 3'b000;
        busy        = (state_q != StIdle);
    end

endmodule
